// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit: fetch PC owner, single-outstanding req/ack fetch FSM, prefetch FIFO
// Revision: 1.0
// ============================================================================
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   Stall,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   instr_valid,
  output logic [31:0]            Instr,
  output logic [XLEN-1:0]        instr_pc,
  output logic [XLEN-1:0]        instr_pc8,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Bit 0 of the state is the request strobe, so imem_req comes straight off a flop.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_KILL = 2'b11;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     word_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic            push, pop, has_room;

  assign push     = (state_q == S_REQ) & imem_ack & ~redirect;
  assign pop      = (count_q != '0) & ~Stall & ~redirect;
  assign count_d  = redirect ? '0 : (count_q + CW'(push) - CW'(pop));
  assign has_room = (count_d < FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = S_REQ;
        end else if (has_room) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            fetch_pc_d = redirect_pc;
            state_d    = S_REQ;
          end else begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            state_d    = has_room ? S_REQ : S_IDLE;
          end
        end else if (redirect) begin
          pending_pc_d = redirect_pc;
          state_d      = S_KILL;
        end
      end
      S_KILL: begin
        // The stale word is still owed; hold the old address until it arrives.
        if (imem_ack) begin
          fetch_pc_d = redirect ? redirect_pc : pending_pc_q;
          state_d    = S_REQ;
        end else if (redirect) begin
          pending_pc_d = redirect_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = state_q[0];
    imem_addr   = fetch_pc_q;
    instr_valid = (count_q != '0);
    Instr       = instr_valid ? word_mem[rd_ptr_q] : '0;
    instr_pc    = instr_valid ? pc_mem[rd_ptr_q] : '0;
    instr_pc8   = instr_pc + XLEN'(8);
    count       = count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit: directed self-checking bench for fetch_unit (32-bit and 16-bit)
// Revision: 1.0
// ============================================================================
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit instance, RESET_PC = 0x100, memory latency programmable
  logic        rst_n = 1'b0;
  logic        req, ack, stall = 1'b0, redir = 1'b0, valid;
  logic [31:0] addr, rdata, redir_pc = '0, instr, ipc, ipc8;
  logic [2:0]  cnt;
  int          lat = 0;
  int          mcnt = 0;

  assign ack   = req && (mcnt >= lat);
  assign rdata = addr;
  always @(posedge clk) begin
    if (!req || ack) mcnt <= 0;
    else             mcnt <= mcnt + 1;
  end

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h100)) u_dut (
    .clk(clk), .reset(rst_n), .imem_req(req), .imem_addr(addr), .imem_ack(ack),
    .imem_rdata(rdata), .Stall(stall), .redirect(redir), .redirect_pc(redir_pc),
    .instr_valid(valid), .Instr(instr), .instr_pc(ipc), .instr_pc8(ipc8), .count(cnt)
  );

  // 16-bit instance, RESET_PC = 0, zero-latency memory
  logic        rst16_n = 1'b0;
  logic        req16, ack16, stall16 = 1'b0, redir16 = 1'b0, valid16;
  logic [15:0] addr16, redir_pc16 = '0, ipc16, ipc8_16;
  logic [31:0] rdata16, instr16;
  logic [2:0]  cnt16;

  assign ack16   = req16;
  assign rdata16 = {16'h0000, addr16};

  fetch_unit #(.XLEN(16), .DEPTH(4), .RESET_PC(16'h0000)) u_dut16 (
    .clk(clk), .reset(rst16_n), .imem_req(req16), .imem_addr(addr16), .imem_ack(ack16),
    .imem_rdata(rdata16), .Stall(stall16), .redirect(redir16), .redirect_pc(redir_pc16),
    .instr_valid(valid16), .Instr(instr16), .instr_pc(ipc16), .instr_pc8(ipc8_16), .count(cnt16)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut(input logic st, input int l);
    @(negedge clk);
    rst_n = 1'b0; redir = 1'b0; stall = st; lat = l;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req); end
    checks++; if (addr !== 32'h100) begin errors++; $display("FAIL reset_addr: got %h expected 00000100", addr); end
    checks++; if (cnt !== 3'd0 || valid !== 1'b0) begin errors++; $display("FAIL reset_count: got %0d/%b expected 0/0", cnt, valid); end
    checks++; if (instr !== 32'h0 || ipc !== 32'h0 || ipc8 !== 32'h8) begin errors++; $display("FAIL reset_head: got %h %h %h expected 0 0 8", instr, ipc, ipc8); end
    checks++; if (addr16 !== 16'h0 || req16 !== 1'b0) begin errors++; $display("FAIL reset16: got %h/%b expected 0000/0", addr16, req16); end
    rst16_n = 1'b1;
  endtask

  task automatic test_stream();
    @(negedge clk);
    checks++; if (req16 !== 1'b1 || addr16 !== 16'h0 || valid16 !== 1'b0) begin errors++; $display("FAIL stream_first_req: got %b %h %b expected 1 0000 0", req16, addr16, valid16); end
    @(negedge clk);
    checks++; if (valid16 !== 1'b1 || instr16 !== 32'h0 || ipc16 !== 16'h0 || ipc8_16 !== 16'h8) begin errors++; $display("FAIL stream_first_instr: got %b %h %h %h expected 1 0 0 8", valid16, instr16, ipc16, ipc8_16); end
    checks++; if (addr16 !== 16'h4) begin errors++; $display("FAIL stream_addr1: got %h expected 0004", addr16); end
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (addr16 !== 16'(4 * (k - 1)) || ipc16 !== 16'(4 * (k - 2)) || instr16 !== 32'(4 * (k - 2)) || cnt16 !== 3'd1) begin
        errors++;
        $display("FAIL stream_k%0d: got addr %h pc %h instr %h count %0d expected addr %h pc %h count 1", k, addr16, ipc16, instr16, cnt16, 16'(4 * (k - 1)), 16'(4 * (k - 2)));
      end
    end
  endtask

  task automatic test_stall_fill();
    reset_dut(1'b1, 0);
    repeat (6) @(negedge clk);
    checks++; if (cnt !== 3'd4 || req !== 1'b0) begin errors++; $display("FAIL full_state: got count %0d req %b expected 4 0", cnt, req); end
    checks++; if (addr !== 32'h110 || instr !== 32'h100) begin errors++; $display("FAIL full_head: got addr %h instr %h expected 00000110 00000100", addr, instr); end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (req !== 1'b1 || addr !== 32'h110 || cnt !== 3'd3) begin errors++; $display("FAIL resume: got req %b addr %h count %0d expected 1 00000110 3", req, addr, cnt); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (instr !== 32'h104 + 32'(4 * i)) begin errors++; $display("FAIL drain_%0d: got %h expected %h", i, instr, 32'h104 + 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect_ack();
    reset_dut(1'b1, 0);
    repeat (4) @(negedge clk);
    checks++; if (cnt !== 3'd3 || ack !== 1'b1) begin errors++; $display("FAIL redir_pre: got count %0d ack %b expected 3 1", cnt, ack); end
    redir = 1'b1; redir_pc = 32'h2000;
    @(negedge clk);
    redir = 1'b0; stall = 1'b0;
    checks++; if (cnt !== 3'd0 || valid !== 1'b0 || addr !== 32'h2000 || req !== 1'b1) begin errors++; $display("FAIL redir_flush: got count %0d valid %b addr %h req %b expected 0 0 00002000 1", cnt, valid, addr, req); end
    @(negedge clk);
    checks++; if (valid !== 1'b1 || ipc !== 32'h2000 || instr !== 32'h2000) begin errors++; $display("FAIL redir_first: got valid %b pc %h instr %h expected 1 00002000 00002000", valid, ipc, instr); end
  endtask

  task automatic test_kill();
    reset_dut(1'b0, 3);
    @(negedge clk);
    checks++; if (req !== 1'b1 || addr !== 32'h100) begin errors++; $display("FAIL kill_issue: got %b %h expected 1 00000100", req, addr); end
    @(negedge clk);
    redir = 1'b1; redir_pc = 32'h40;
    @(negedge clk);
    redir = 1'b0;
    checks++; if (req !== 1'b1 || addr !== 32'h100) begin errors++; $display("FAIL kill_hold: got %b %h expected 1 00000100", req, addr); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (addr !== 32'h40 || cnt !== 3'd0 || valid !== 1'b0) begin errors++; $display("FAIL kill_refetch: got addr %h count %0d valid %b expected 00000040 0 0", addr, cnt, valid); end
    repeat (4) @(negedge clk);
    checks++; if (valid !== 1'b1 || ipc !== 32'h40) begin errors++; $display("FAIL kill_first: got valid %b pc %h expected 1 00000040", valid, ipc); end
  endtask

  task automatic test_double_redirect();
    reset_dut(1'b0, 3);
    @(negedge clk);
    redir = 1'b1; redir_pc = 32'h40;
    @(negedge clk);
    redir_pc = 32'h80;
    @(negedge clk);
    redir = 1'b0;
    checks++; if (addr !== 32'h100) begin errors++; $display("FAIL dbl_hold: got %h expected 00000100", addr); end
    repeat (2) @(negedge clk);
    checks++; if (addr !== 32'h80 || req !== 1'b1) begin errors++; $display("FAIL dbl_refetch: got %h %b expected 00000080 1", addr, req); end
    repeat (4) @(negedge clk);
    checks++; if (valid !== 1'b1 || ipc !== 32'h80) begin errors++; $display("FAIL dbl_first: got valid %b pc %h expected 1 00000080", valid, ipc); end
  endtask

  task automatic test_kill_ack_redirect();
    reset_dut(1'b0, 3);
    @(negedge clk);
    redir = 1'b1; redir_pc = 32'h40;
    @(negedge clk);
    redir = 1'b0;
    repeat (2) @(negedge clk);
    redir = 1'b1; redir_pc = 32'hC0;
    @(negedge clk);
    redir = 1'b0;
    checks++; if (addr !== 32'hC0 || cnt !== 3'd0) begin errors++; $display("FAIL kill_ack_redir: got addr %h count %0d expected 000000c0 0", addr, cnt); end
  endtask

  task automatic test_wrap16();
    redir16 = 1'b1; redir_pc16 = 16'hFFFC;
    @(negedge clk);
    redir16 = 1'b0;
    checks++; if (addr16 !== 16'hFFFC || cnt16 !== 3'd0) begin errors++; $display("FAIL wrap_redir: got %h %0d expected fffc 0", addr16, cnt16); end
    @(negedge clk);
    stall16 = 1'b1;
    checks++; if (addr16 !== 16'h0000) begin errors++; $display("FAIL wrap_addr: got %h expected 0000", addr16); end
    checks++; if (ipc16 !== 16'hFFFC || ipc8_16 !== 16'h0004 || instr16 !== 32'h0000FFFC) begin errors++; $display("FAIL wrap_head: got pc %h pc8 %h instr %h expected fffc 0004 0000fffc", ipc16, ipc8_16, instr16); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    checks++; if (cnt16 !== 3'd2 || req16 !== 1'b1) begin errors++; $display("FAIL async_pre: got count %0d req %b expected 2 1", cnt16, req16); end
    rst16_n = 1'b0;
    #1;
    checks++; if (req16 !== 1'b0 || cnt16 !== 3'd0 || valid16 !== 1'b0 || addr16 !== 16'h0) begin errors++; $display("FAIL async_reset: got req %b count %0d valid %b addr %h expected 0 0 0 0000", req16, cnt16, valid16, addr16); end
    @(negedge clk);
    checks++; if (req16 !== 1'b0 || cnt16 !== 3'd0) begin errors++; $display("FAIL async_hold: got req %b count %0d expected 0 0", req16, cnt16); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_fill();
    test_redirect_ack();
    test_kill();
    test_double_redirect();
    test_kill_ack_redirect();
    test_wrap16();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
